seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode seven-segment digits. It shares one hex-to-segment decode path across `DIGITS` digit positions, rotating a one-cold digit select at a fixed slot rate. New display contents are loaded through a valid/ready handshake and committed atomically at frame boundaries, so a frame never mixes old and new values. It sits between the core's display/debug register writes and the board's segment and anode pins.

## Interface
- `DIGITS`, default 8: number of digit positions; legal range 1..8.
- `DIV`, default 1000: clock cycles per digit slot; must be ≥ 2.
- `GAP_CYC`, default 4: blanking cycles after each slot; used only with `SEG_SCAN_GAP_EN`; must be ≥ 1.
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `wr_valid`, input, 1: a new display image is offered.
- `wr_ready`, output, 1: the controller can accept an image.
- `wr_data`, input, 4*DIGITS: hex nibble per digit; digit i uses `[4i+3:4i]`.
- `wr_dp`, input, DIGITS: decimal point per digit, 1 = lit.
- `wr_blank`, input, DIGITS: 1 = digit dark.
- `seg`, output, 8: active-low segments. Bit map: 7=a (top), 6=b (upper right), 5=c (lower right), 4=d (bottom), 3=e (lower left), 2=f (upper left), 1=g (middle), 0=dp.
- `an`, output, DIGITS: active-low digit select, at most one bit low.
- `frame_done`, output, 1: one-cycle pulse when the digit index wraps.

## Operation
- **State.** Slot counter `cnt` (0..DIV-1), digit index `idx` (width max(1, clog2(DIGITS))), active image, pending image, and a `pend` flag.
- **Handshake.**
  - `wr_ready = !pend`.
  - On `wr_valid && wr_ready`, the image is copied to pending and `pend` is set to 1.
  - While `pend` is 1, `wr_valid` is ignored.
- **Slot advance.**
  - When `cnt == DIV-1`: `cnt` goes to 0 and `idx` increments.
  - When `idx == DIGITS-1` at that point, `idx` wraps to 0. This is the frame boundary.
- **Frame boundary.**
  - `frame_done` pulses.
  - If `pend` is 1, the pending image is copied to active and `pend` clears; `wr_ready` rises on the next cycle.
  - An image accepted on the boundary cycle itself goes to pending and is committed at the following boundary.
- **Decode.** The nibble maps to active-high pattern bits {a..g, 0}:
  - 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6
  - 6=BE, 7=E0, 8=FE, 9=F6, A=EE, b=3E
  - C=9C, d=7A, E=9E, F=8E
  - Bit 0 is then replaced by `dp[idx]`, and the whole byte is inverted to form `seg`.
- **Blank.** If `blank[idx]` is 1: `seg = 8'hFF` and `an` is all ones.
- **Output drive.** Otherwise `an = ~(1 << idx)`.

## Timing
- **Reset values.**
  - `seg = 8'hFF`, `an` all ones, `frame_done = 0`, `wr_ready = 1`.
  - `cnt = 0`, `idx = 0`, `pend = 0`.
  - Active image: data 0, dp 0, blank all ones (dark until the first commit).
- **Reset mid-operation.** Reset at any cycle discards the pending image and restores all reset values on the next edge.
- **Output registers.** `seg` and `an` are registered from the current `idx` and active image, so they lag an `idx` or image change by exactly 1 cycle.
- **Frame length.** A frame without gap is `DIGITS*DIV` cycles. `frame_done` is registered and asserts on the cycle after the wrap edge.
- **Commit latency.** From image acceptance to its first appearance on the pins:
  - minimum 2 cycles (accept one cycle before a boundary);
  - maximum frame length + 1 cycles.
- **DIGITS = 1.** `idx` stays 0, and every slot end is a frame boundary.

## Configuration
- **`SEG_SCAN_GAP_EN` defined.**
  - Adds a two-state FSM: `S_SHOW` (DIV cycles) → `S_GAP` (GAP_CYC cycles) → `S_SHOW`.
  - `idx` advances on exit from `S_GAP`, and the frame boundary is evaluated at that point.
  - During `S_GAP`: `an` all ones and `seg = 8'hFF` (anti-ghosting).
  - Frame length = `DIGITS*(DIV+GAP_CYC)`.
  - Reset enters `S_SHOW`.
- **`SEG_SCAN_GAP_EN` undefined.**
  - There is no FSM and no gap.
  - `GAP_CYC` is ignored.

## Structure
- **Shared package (`seg_pkg`):** the 16 segment pattern constants, the segment bit index constants (`SEG_A`..`SEG_DP`), and the blank pattern `8'hFF`.
- **Sub-module `seg_hex_decode`:** combinational, nibble + dp → active-low byte. It is instantiated once and shared across all digits.
- **Top level (`seg_scan_ctrl`):** holds the counters, the FSM, the image registers and the output registers.

## Test plan
All scenarios use `DIGITS=4` and `DIV=4`.
1. **Reset, no writes:** hold `rst` 3 cycles, then release and run 40 cycles with no writes → `seg=8'hFF`, `an=4'hF`, `wr_ready=1` throughout; `frame_done` pulses every 16 cycles.
2. **First write:** write `wr_data=16'h1234`, `dp=0`, `blank=0` → `wr_ready` falls the next cycle. After the boundary, slot 0 shows `an=4'b1110`, `seg=8'h99`, and slot 3 shows `an=4'b0111`, `seg=8'h9F`. `wr_ready` returns to 1.
3. **Write while pending:** hold `wr_valid` with `16'hFFFF` while pending `16'h1234` is outstanding → the second image is not taken until `wr_ready=1`, then commits one boundary later. Slot 0 then shows `seg=8'h71`.
4. **Blank and dp:** `blank=4'b0100`, `dp=4'b0001`, data `16'h8888` → slot 2: `an=4'hF`, `seg=8'hFF`; slot 0: `seg=8'h00`; slot 1: `seg=8'h01`.
5. **Reset mid-operation:** assert `rst` in the middle of slot 2 with an image pending → next cycle matches the reset values; the pending image is never displayed.
6. **Gap macro:** `SEG_SCAN_GAP_EN` defined with `GAP_CYC=2` → `frame_done` spacing is 24 cycles, with 2 dark cycles after each slot. Without the macro, the spacing is 16 cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: segment bit map,
// hex glyph table, blank pattern, scan FSM states and a width helper.
package seg_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-high glyphs {a,b,c,d,e,f,g,0}; index is the hex nibble
  localparam logic [7:0] SEG_PAT [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  typedef enum logic {
    S_SHOW = 1'b0,
    S_GAP  = 1'b1
  } scan_state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Image-load handshake and display pins of the scan controller.
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 8
);
  // Handshake: an image transfers on every rising clk edge where wr_valid and
  // wr_ready are both 1. The offerer holds wr_valid and the image stable until
  // that edge; wr_ready may drop at any time and never depends on wr_valid.
  logic                wr_valid;
  logic                wr_ready;
  logic [4*DIGITS-1:0] wr_data;
  logic [DIGITS-1:0]   wr_dp;
  logic [DIGITS-1:0]   wr_blank;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                frame_done;

  modport master (
    output wr_valid, wr_data, wr_dp, wr_blank,
    input  wr_ready, seg, an, frame_done
  );

  modport slave (
    input  wr_valid, wr_data, wr_dp, wr_blank,
    output wr_ready, seg, an, frame_done
  );
endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble + decimal point to active-low segment byte.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg_n
);
  logic [7:0] pat;

  always_comb begin
    pat         = SEG_PAT[nib];
    pat[SEG_DP] = dp;
    seg_n       = ~pat;
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame-atomic image commit.
// Define SEG_SCAN_GAP_EN to add a dark anti-ghosting gap after every digit slot.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS  = 8,
  parameter int DIV     = 1000,
  parameter int GAP_CYC = 4
) (
  input  logic           clk,
  input  logic           rst,
  seg_scan_ctrl_if.slave bus,
  output scan_state_t    dbg_state
);
  localparam int IDXW    = clog2_min1(DIGITS);
  localparam int CNT_MAX = (DIV > GAP_CYC) ? DIV : GAP_CYC;
  localparam int CW      = clog2_min1(CNT_MAX);

  logic [CW-1:0]       cnt;
  logic [IDXW-1:0]     idx;
  logic                pend;
  logic [4*DIGITS-1:0] act_data, pnd_data;
  logic [DIGITS-1:0]   act_dp, act_blank, pnd_dp, pnd_blank;
  logic [7:0]          seg_q;
  logic [DIGITS-1:0]   an_q;
  logic                frame_done_q;
  logic                slot_end, wrap, dark;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_blank;
  logic [7:0]          dec_seg;
  scan_state_t         state;

`ifdef SEG_SCAN_GAP_EN
  // cnt times the show phase (DIV) and then the gap phase (GAP_CYC)
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_SHOW;
      cnt   <= '0;
    end else if (state == S_SHOW) begin
      if (cnt == CW'(DIV - 1)) begin
        state <= S_GAP;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      if (cnt == CW'(GAP_CYC - 1)) begin
        state <= S_SHOW;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign slot_end = (state == S_GAP) && (cnt == CW'(GAP_CYC - 1));
  assign dark     = (state == S_GAP);
`else
  always_ff @(posedge clk) begin
    if (rst || slot_end) cnt <= '0;
    else                 cnt <= cnt + CW'(1);
  end

  assign state    = S_SHOW;
  assign slot_end = (cnt == CW'(DIV - 1));
  assign dark     = 1'b0;
`endif

  assign dbg_state = state;
  assign wrap      = slot_end && (idx == IDXW'(DIGITS - 1));

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDXW'(i)) begin
        cur_nib   = act_data[4*i +: 4];
        cur_dp    = act_dp[i];
        cur_blank = act_blank[i];
      end
    end
  end

  seg_hex_decode u_dec (
    .nib   (cur_nib),
    .dp    (cur_dp),
    .seg_n (dec_seg)
  );

  // Accept and commit are exclusive: accept needs !pend, commit needs pend
  always_ff @(posedge clk) begin
    if (rst) begin
      idx          <= '0;
      pend         <= 1'b0;
      act_data     <= '0;
      act_dp       <= '0;
      act_blank    <= '1;
      pnd_data     <= '0;
      pnd_dp       <= '0;
      pnd_blank    <= '1;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= wrap;
      if (slot_end) idx <= wrap ? '0 : idx + IDXW'(1);

      if (bus.wr_valid && !pend) begin
        pnd_data  <= bus.wr_data;
        pnd_dp    <= bus.wr_dp;
        pnd_blank <= bus.wr_blank;
        pend      <= 1'b1;
      end else if (wrap && pend) begin
        act_data  <= pnd_data;
        act_dp    <= pnd_dp;
        act_blank <= pnd_blank;
        pend      <= 1'b0;
      end

      if (dark || cur_blank) begin
        seg_q <= SEG_BLANK;
        an_q  <= '1;
      end else begin
        seg_q <= dec_seg;
        an_q  <= ~(DIGITS'(1) << idx);
      end
    end
  end

  assign bus.wr_ready   = !pend;
  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (DIGITS=4, DIV=4, GAP_CYC=2); the reference
// model derives every pin from the cycle count since reset and the committed image.
module tb_seg_scan_ctrl;
  localparam int DIGITS  = 4;
  localparam int DIV     = 4;
  localparam int GAP_CYC = 2;
`ifdef SEG_SCAN_GAP_EN
  localparam int SL = DIV + GAP_CYC;
`else
  localparam int SL = DIV;
`endif
  localparam int FRAME = DIGITS * SL;
  localparam int W     = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  seg_pkg::scan_state_t dbg_state;

  seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_ctrl #(
    .DIGITS  (DIGITS),
    .DIV     (DIV),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  bit started = 1'b0;

  logic [7:0] hex_pat [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // reference model: edge k after reset shows the digit of cycle k-1
  int unsigned m_k;
  bit          m_pend;
  logic [15:0] a_data, p_data;
  logic [3:0]  a_dp, a_bl, p_dp, p_bl;

  always @(posedge clk) begin
    int ph, di;
    bit dark, bnd;
    logic [3:0] nib, e_an;
    logic [7:0] pat, e_seg;
    if (rst) begin
      m_k    = 0;
      m_pend = 1'b0;
      a_data = '0;
      a_dp   = '0;
      a_bl   = '1;
      exp_q.push_back({1'b0, 1'b1, 4'hF, 8'hFF});
    end else begin
      m_k++;
      ph    = int'((m_k - 1) % SL);
      di    = int'(((m_k - 1) / SL) % DIGITS);
      dark  = (ph >= DIV) || a_bl[di];
      nib   = a_data[4*di +: 4];
      pat   = hex_pat[nib];
      e_seg = dark ? 8'hFF : ~{pat[7:1], a_dp[di]};
      e_an  = dark ? 4'hF : ~(4'b0001 << di);
      bnd   = (m_k % FRAME) == 0;
      if (bus.wr_valid && !m_pend) begin
        p_data = bus.wr_data;
        p_dp   = bus.wr_dp;
        p_bl   = bus.wr_blank;
        m_pend = 1'b1;
      end else if (bnd && m_pend) begin
        a_data = p_data;
        a_dp   = p_dp;
        a_bl   = p_bl;
        m_pend = 1'b0;
      end
      exp_q.push_back({bnd, !m_pend, e_an, e_seg});
    end
    started = 1'b1;
  end

  // monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (started) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL queue: no expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("frame_done", {7'b0, bus.frame_done}, {7'b0, e[13]});
        chk("wr_ready", {7'b0, bus.wr_ready}, {7'b0, e[12]});
        chk("an", {4'b0, bus.an}, {4'b0, e[11:8]});
        chk("seg", bus.seg, e[7:0]);
      end
    end
  end

  // driver tasks
  task automatic write_img(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    int n;
    n = 0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    bus.wr_dp    = dp;
    bus.wr_blank = bl;
    forever begin
      @(negedge clk);
      if (bus.wr_ready === 1'b1) break;
      n++;
      if (n > 2 * FRAME) begin
        n_checks++;
        n_fail++;
        $display("FAIL write_img: got wr_ready=0 for %0d cycles want 1", n);
        break;
      end
    end
    @(posedge clk);
    #1 bus.wr_valid = 1'b0;
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_done !== 1'b1 && n <= 2 * FRAME);
    chk("wait_frame", {7'b0, bus.frame_done}, 8'h01);
  endtask

  task automatic check_slot(input logic [3:0] an_w, input logic [7:0] seg_w, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.an !== an_w && n <= 2 * FRAME);
    if (bus.an !== an_w) chk({name, "_an"}, {4'b0, bus.an}, {4'b0, an_w});
    else                 chk(name, bus.seg, seg_w);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.wr_dp    = '0;
    bus.wr_blank = '0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // idle after reset: dark, ready, periodic frame_done
    repeat (40) @(posedge clk);
    #1;

    write_img(16'h1234, 4'h0, 4'h0);
    wait_frame();
    check_slot(4'b1110, 8'h99, "img1234_slot0");
    check_slot(4'b0111, 8'h9F, "img1234_slot3");

    // second image held while the first is still pending
    write_img(16'h5678, 4'h0, 4'h0);
    write_img(16'hFFFF, 4'h0, 4'h0);
    wait_frame();
    check_slot(4'b1110, 8'h71, "imgFFFF_slot0");

    write_img(16'h8888, 4'b0001, 4'b0100);
    wait_frame();
    check_slot(4'b1110, 8'h00, "dp_slot0");
    check_slot(4'b1101, 8'h01, "dp_slot1");

    // reset in the middle of slot 2 with an image pending
    wait_frame();
    write_img(16'hABCD, 4'hF, 4'h0);
    repeat (8) @(posedge clk);
    #1 pulse_reset();
    repeat (2 * FRAME + 4) @(posedge clk);
    #1;

    for (int i = 0; i < 30; i++) begin
      int gap;
      logic [3:0] bl;
      gap = $urandom_range(0, 20);
      repeat (gap) begin
        @(posedge clk);
        #1;
        bus.wr_data  = 16'($urandom);
        bus.wr_dp    = 4'($urandom);
        bus.wr_blank = 4'($urandom);
      end
      bl = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      write_img(16'($urandom), 4'($urandom), bl);
      if (i == 17) begin
        repeat ($urandom_range(0, FRAME)) @(posedge clk);
        #1 pulse_reset();
      end
    end

    repeat (FRAME + 4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
